// File: rtl/writeback_top_if.sv
// Execute -> writeback handshake bundle.
// The execute stage drives the op fields and wb_valid through the master modport.
// Writeback returns wb_ready through the slave modport.
interface writeback_top_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_dest_address;
    logic [31:0]       wb_dest_reg;
    logic [DATA_W-1:0] wb_result;
    logic [2:0]        wb_opsize;
    logic              wb_op_a_is_address;
    logic              wb_op_a_is_segment;
    logic              wb_op_a_is_mmx;
    logic              wb_op_a_is_reg;
    logic              wb_jump_load_address;
    logic              wb_br_misprediction;
    logic [ADDR_W-1:0] wb_jump_address;
    logic [5:0]        wb_eflags;

    modport master (
        output wb_valid, wb_dest_address, wb_dest_reg, wb_result, wb_opsize,
               wb_op_a_is_address, wb_op_a_is_segment, wb_op_a_is_mmx, wb_op_a_is_reg,
               wb_jump_load_address, wb_br_misprediction, wb_jump_address, wb_eflags,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_dest_address, wb_dest_reg, wb_result, wb_opsize,
               wb_op_a_is_address, wb_op_a_is_segment, wb_op_a_is_mmx, wb_op_a_is_reg,
               wb_jump_load_address, wb_br_misprediction, wb_jump_address, wb_eflags,
        output wb_ready
    );
endinterface

// File: rtl/writeback_top.sv
// Writeback stage: consumer end of the execute->writeback handshake.
// Commits GPR/segment/MMX writes, memory stores (64-bit stores split into two
// 32-bit writes), frontend redirects and architectural flags.
// Optional feature macro: WB_RETIRE_CNT_EN enables the retired-op counter;
// without it retired_count is tied to zero.
module writeback_top #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    writeback_top_if.slave    wb,
    output logic              rf_we,
    output logic [2:0]        rf_wreg,
    output logic [2:0]        rf_wsize,
    output logic [31:0]       rf_wdata,
    output logic              seg_we,
    output logic [2:0]        seg_wreg,
    output logic [15:0]       seg_wdata,
    output logic              mmx_we,
    output logic [2:0]        mmx_wreg,
    output logic [DATA_W-1:0] mmx_wdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              fe_redirect,
    output logic [ADDR_W-1:0] fe_redirect_addr,
    output logic [5:0]        eflags_arch,
    output logic [31:0]       retired_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MEM_LO = 2'b01,
        ST_MEM_HI = 2'b10
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              sel_mem;
    logic              sel_seg;
    logic              sel_mmx;
    logic              sel_reg;
    logic              redirect;
    logic              store_done;
    logic [1:0]        size_map;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [1:0]        st_size;
    logic              st_is64;
    logic              unused_bits;

    assign wb.wb_ready = (state_q == ST_IDLE);
    assign accept      = wb.wb_valid & wb.wb_ready & ~flush;
    assign redirect    = wb.wb_jump_load_address | wb.wb_br_misprediction;

    // Destination priority: address > segment > mmx > reg
    assign sel_mem = wb.wb_op_a_is_address;
    assign sel_seg = ~wb.wb_op_a_is_address & wb.wb_op_a_is_segment;
    assign sel_mmx = ~wb.wb_op_a_is_address & ~wb.wb_op_a_is_segment & wb.wb_op_a_is_mmx;
    assign sel_reg = ~wb.wb_op_a_is_address & ~wb.wb_op_a_is_segment & ~wb.wb_op_a_is_mmx
                   & wb.wb_op_a_is_reg;

    assign unused_bits = ^{wb.wb_dest_reg[31:3], store_done};

    // Translate the op size encoding into the store port size code
    always_comb begin
        size_map = 2'b10;
        case (wb.wb_opsize)
            3'b001:  size_map = 2'b00;
            3'b010:  size_map = 2'b01;
            default: size_map = 2'b10;
        endcase
    end

    // Store FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Store FSM next state; store_done marks the final ack of a store
    always_comb begin
        state_d    = state_q;
        store_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && sel_mem) state_d = ST_MEM_LO;
            end
            ST_MEM_LO: begin
                if (mem_ack) begin
                    if (st_is64) begin
                        state_d = ST_MEM_HI;
                    end else begin
                        state_d    = ST_IDLE;
                        store_done = 1'b1;
                    end
                end
            end
            ST_MEM_HI: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    store_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Store port request flop, high while the FSM is in a memory state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mem_req <= 1'b0;
        else        mem_req <= (state_d != ST_IDLE);
    end

    // Store port address/data/size decoded from the latched store and current half
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = '0;
        case (state_q)
            ST_MEM_LO: begin
                mem_addr  = st_addr;
                mem_wdata = st_data[31:0];
                mem_size  = st_size;
            end
            ST_MEM_HI: begin
                mem_addr  = st_addr + ADDR_W'(4);
                mem_wdata = st_data[63:32];
                mem_size  = 2'b10;
            end
            default: ;
        endcase
    end

    // Latch the store operands when a memory op is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_addr <= '0;
            st_data <= '0;
            st_size <= '0;
            st_is64 <= 1'b0;
        end else if (accept && sel_mem) begin
            st_addr <= wb.wb_dest_address;
            st_data <= wb.wb_result;
            st_size <= size_map;
            st_is64 <= (wb.wb_opsize == 3'b111);
        end
    end

    // Register-class writes, redirect pulse and flag commit, one cycle after accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we            <= 1'b0;
            rf_wreg          <= '0;
            rf_wsize         <= '0;
            rf_wdata         <= '0;
            seg_we           <= 1'b0;
            seg_wreg         <= '0;
            seg_wdata        <= '0;
            mmx_we           <= 1'b0;
            mmx_wreg         <= '0;
            mmx_wdata        <= '0;
            fe_redirect      <= 1'b0;
            fe_redirect_addr <= '0;
            eflags_arch      <= '0;
        end else begin
            rf_we       <= accept & sel_reg;
            seg_we      <= accept & sel_seg;
            mmx_we      <= accept & sel_mmx;
            fe_redirect <= accept & redirect;
            if (accept && sel_reg) begin
                rf_wreg  <= wb.wb_dest_reg[2:0];
                rf_wsize <= wb.wb_opsize;
                rf_wdata <= wb.wb_result[31:0];
            end
            if (accept && sel_seg) begin
                seg_wreg  <= wb.wb_dest_reg[2:0];
                seg_wdata <= wb.wb_result[15:0];
            end
            if (accept && sel_mmx) begin
                mmx_wreg  <= wb.wb_dest_reg[2:0];
                mmx_wdata <= wb.wb_result;
            end
            if (accept && redirect) fe_redirect_addr <= wb.wb_jump_address;
            if (accept)             eflags_arch      <= wb.wb_eflags;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_q;

    // Retired-op counter: non-store ops retire at accept, stores at their final ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  retired_q <= '0;
        else if ((accept && !sel_mem) || store_done) retired_q <= retired_q + 32'd1;
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_writeback_top.sv
// Directed self-checking bench for writeback_top.
// Inputs change 1 ns after the rising edge; outputs are checked in that same
// window, so registered outputs reflect the edge just taken.
module tb_writeback_top;

`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        rf_we;
    logic [2:0]  rf_wreg;
    logic [2:0]  rf_wsize;
    logic [31:0] rf_wdata;
    logic        seg_we;
    logic [2:0]  seg_wreg;
    logic [15:0] seg_wdata;
    logic        mmx_we;
    logic [2:0]  mmx_wreg;
    logic [63:0] mmx_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        fe_redirect;
    logic [31:0] fe_redirect_addr;
    logic [5:0]  eflags_arch;
    logic [31:0] retired_count;

    int unsigned n_cmp;
    int unsigned n_err;

    writeback_top_if #(.ADDR_W(32), .DATA_W(64)) wb_bus ();

    writeback_top #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .wb               (wb_bus),
        .rf_we            (rf_we),
        .rf_wreg          (rf_wreg),
        .rf_wsize         (rf_wsize),
        .rf_wdata         (rf_wdata),
        .seg_we           (seg_we),
        .seg_wreg         (seg_wreg),
        .seg_wdata        (seg_wdata),
        .mmx_we           (mmx_we),
        .mmx_wreg         (mmx_wreg),
        .mmx_wdata        (mmx_wdata),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_size         (mem_size),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .fe_redirect      (fe_redirect),
        .fe_redirect_addr (fe_redirect_addr),
        .eflags_arch      (eflags_arch),
        .retired_count    (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_op(input logic is_addr, input logic is_seg, input logic is_mmx,
                          input logic is_reg, input logic [2:0] dreg, input logic [63:0] res,
                          input logic [2:0] sz, input logic [31:0] addr, input logic jmp,
                          input logic mis, input logic [31:0] jaddr, input logic [5:0] fl);
        wb_bus.wb_valid             = 1'b1;
        wb_bus.wb_op_a_is_address   = is_addr;
        wb_bus.wb_op_a_is_segment   = is_seg;
        wb_bus.wb_op_a_is_mmx       = is_mmx;
        wb_bus.wb_op_a_is_reg       = is_reg;
        wb_bus.wb_dest_reg          = {29'd0, dreg};
        wb_bus.wb_result            = res;
        wb_bus.wb_opsize            = sz;
        wb_bus.wb_dest_address      = addr;
        wb_bus.wb_jump_load_address = jmp;
        wb_bus.wb_br_misprediction  = mis;
        wb_bus.wb_jump_address      = jaddr;
        wb_bus.wb_eflags            = fl;
    endtask

    task automatic no_op();
        wb_bus.wb_valid             = 1'b0;
        wb_bus.wb_op_a_is_address   = 1'b0;
        wb_bus.wb_op_a_is_segment   = 1'b0;
        wb_bus.wb_op_a_is_mmx       = 1'b0;
        wb_bus.wb_op_a_is_reg       = 1'b0;
        wb_bus.wb_jump_load_address = 1'b0;
        wb_bus.wb_br_misprediction  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        flush = 1'b0;
        mem_ack = 1'b0;
        wb_bus.wb_dest_reg     = '0;
        wb_bus.wb_result       = '0;
        wb_bus.wb_opsize       = '0;
        wb_bus.wb_dest_address = '0;
        wb_bus.wb_jump_address = '0;
        wb_bus.wb_eflags       = '0;
        no_op();

        // Reset state
        tick();
        tick();
        check_val("rst_ready",   64'(wb_bus.wb_ready), 64'd1);
        check_val("rst_rf_we",   64'(rf_we), 64'd0);
        check_val("rst_mem_req", 64'(mem_req), 64'd0);
        check_val("rst_redir",   64'(fe_redirect), 64'd0);
        check_val("rst_eflags",  64'(eflags_arch), 64'd0);
        check_val("rst_count",   64'(retired_count), 64'd0);
        reset = 1'b1;
        tick();

        // GPR write
        put_op(0, 0, 0, 1, 3'd3, 64'h1234_5678_9ABC_DEF0, 3'b100, 32'h0, 0, 0, 32'h0, 6'h15);
        check_val("gpr_ready_pre", 64'(wb_bus.wb_ready), 64'd1);
        tick();
        no_op();
        check_val("gpr_we",     64'(rf_we), 64'd1);
        check_val("gpr_wreg",   64'(rf_wreg), 64'd3);
        check_val("gpr_wsize",  64'(rf_wsize), 64'd4);
        check_val("gpr_wdata",  64'(rf_wdata), 64'h9ABC_DEF0);
        check_val("gpr_ready",  64'(wb_bus.wb_ready), 64'd1);
        check_val("gpr_eflags", 64'(eflags_arch), 64'h15);
        check_val("gpr_seg_we", 64'(seg_we), 64'd0);
        tick();
        check_val("gpr_we_drop", 64'(rf_we), 64'd0);

        // Back-to-back GPR ops, one per cycle
        put_op(0, 0, 0, 1, 3'd1, 64'h0000_0000_1111_1111, 3'b100, 32'h0, 0, 0, 32'h0, 6'h01);
        tick();
        put_op(0, 0, 0, 1, 3'd2, 64'h0000_0000_2222_2222, 3'b010, 32'h0, 0, 0, 32'h0, 6'h02);
        check_val("b2b_a_wreg",  64'(rf_wreg), 64'd1);
        check_val("b2b_a_wdata", 64'(rf_wdata), 64'h1111_1111);
        tick();
        no_op();
        check_val("b2b_b_we",    64'(rf_we), 64'd1);
        check_val("b2b_b_wreg",  64'(rf_wreg), 64'd2);
        check_val("b2b_b_wsize", 64'(rf_wsize), 64'd2);
        check_val("b2b_b_wdata", 64'(rf_wdata), 64'h2222_2222);

        // Segment beats reg
        put_op(0, 1, 0, 1, 3'd5, 64'hAAAA_BBBB_CCCC_DDDD, 3'b010, 32'h0, 0, 0, 32'h0, 6'h03);
        tick();
        no_op();
        check_val("seg_we",    64'(seg_we), 64'd1);
        check_val("seg_wreg",  64'(seg_wreg), 64'd5);
        check_val("seg_wdata", 64'(seg_wdata), 64'hDDDD);
        check_val("seg_rf_we", 64'(rf_we), 64'd0);

        // MMX beats reg
        put_op(0, 0, 1, 1, 3'd6, 64'hFEDC_BA98_7654_3210, 3'b111, 32'h0, 0, 0, 32'h0, 6'h04);
        tick();
        no_op();
        check_val("mmx_we",    64'(mmx_we), 64'd1);
        check_val("mmx_wreg",  64'(mmx_wreg), 64'd6);
        check_val("mmx_wdata", mmx_wdata, 64'hFEDC_BA98_7654_3210);
        check_val("mmx_rf_we", 64'(rf_we), 64'd0);

        // Redirect pulse and held target
        put_op(0, 0, 0, 1, 3'd0, 64'h0, 3'b100, 32'h0, 0, 1, 32'h0000_8000, 6'h05);
        tick();
        no_op();
        check_val("redir_pulse", 64'(fe_redirect), 64'd1);
        check_val("redir_addr",  64'(fe_redirect_addr), 64'h8000);
        tick();
        check_val("redir_drop",  64'(fe_redirect), 64'd0);
        check_val("redir_hold",  64'(fe_redirect_addr), 64'h8000);

        // Flushed op is dropped entirely
        put_op(0, 0, 0, 1, 3'd7, 64'h5555_5555, 3'b100, 32'h0, 1, 0, 32'h0000_1234, 6'h2A);
        flush = 1'b1;
        tick();
        no_op();
        flush = 1'b0;
        check_val("flush_rf_we",  64'(rf_we), 64'd0);
        check_val("flush_redir",  64'(fe_redirect), 64'd0);
        check_val("flush_eflags", 64'(eflags_arch), 64'h05);
        check_val("flush_raddr",  64'(fe_redirect_addr), 64'h8000);

        // 64b store across the address wrap, with redirect not waiting on the store
        put_op(1, 0, 0, 1, 3'd0, 64'h1111_2222_3333_4444, 3'b111, 32'hFFFF_FFFC, 1, 0, 32'h40, 6'h3F);
        tick();
        no_op();
        check_val("st64_lo_req",   64'(mem_req), 64'd1);
        check_val("st64_lo_addr",  64'(mem_addr), 64'hFFFF_FFFC);
        check_val("st64_lo_data",  64'(mem_wdata), 64'h3333_4444);
        check_val("st64_lo_size",  64'(mem_size), 64'd2);
        check_val("st64_lo_ready", 64'(wb_bus.wb_ready), 64'd0);
        check_val("st64_redir",    64'(fe_redirect), 64'd1);
        check_val("st64_raddr",    64'(fe_redirect_addr), 64'h40);
        check_val("st64_eflags",   64'(eflags_arch), 64'h3F);
        check_val("st64_rf_we",    64'(rf_we), 64'd0);
        tick();
        check_val("st64_lo_wait",  64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("st64_hi_req",   64'(mem_req), 64'd1);
        check_val("st64_hi_addr",  64'(mem_addr), 64'h0000_0000);
        check_val("st64_hi_data",  64'(mem_wdata), 64'h1111_2222);
        check_val("st64_hi_size",  64'(mem_size), 64'd2);
        check_val("st64_hi_ready", 64'(wb_bus.wb_ready), 64'd0);
        tick();
        check_val("st64_hi_wait",  64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("st64_done_req",   64'(mem_req), 64'd0);
        check_val("st64_done_ready", 64'(wb_bus.wb_ready), 64'd1);

        // 32b store in flight survives a flush; the flushed op is not taken
        put_op(1, 0, 0, 0, 3'd0, 64'h0000_0000_DEAD_BEEF, 3'b100, 32'h0000_0100, 0, 0, 32'h0, 6'h11);
        tick();
        put_op(0, 0, 0, 1, 3'd4, 64'h7777_7777, 3'b100, 32'h0, 0, 0, 32'h0, 6'h22);
        flush = 1'b1;
        check_val("st32_size", 64'(mem_size), 64'd2);
        check_val("st32_data", 64'(mem_wdata), 64'hDEAD_BEEF);
        tick();
        check_val("st32_flush_req", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        flush = 1'b0;
        no_op();
        check_val("st32_done_req", 64'(mem_req), 64'd0);
        check_val("st32_rf_we",    64'(rf_we), 64'd0);
        check_val("st32_eflags",   64'(eflags_arch), 64'h11);

        // 8b store acked on the cycle req rises
        put_op(1, 0, 0, 0, 3'd0, 64'h0000_0000_0000_00AB, 3'b001, 32'h0000_0020, 0, 0, 32'h0, 6'h11);
        tick();
        no_op();
        mem_ack = 1'b1;
        check_val("st8_req",  64'(mem_req), 64'd1);
        check_val("st8_size", 64'(mem_size), 64'd0);
        check_val("st8_addr", 64'(mem_addr), 64'h20);
        tick();
        mem_ack = 1'b0;
        check_val("st8_done_req",   64'(mem_req), 64'd0);
        check_val("st8_done_ready", 64'(wb_bus.wb_ready), 64'd1);

        // 16b store size code
        put_op(1, 0, 0, 0, 3'd0, 64'h0000_0000_0000_BEEF, 3'b010, 32'h0000_0030, 0, 0, 32'h0, 6'h11);
        tick();
        no_op();
        mem_ack = 1'b1;
        check_val("st16_size", 64'(mem_size), 64'd1);
        tick();
        mem_ack = 1'b0;
        check_val("st16_done_req", 64'(mem_req), 64'd0);

        // Counter: fresh reset, 3 reg ops then a 64b store
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_val("cnt_rst", 64'(retired_count), 64'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            put_op(0, 0, 0, 1, 3'(i), 64'(i), 3'b100, 32'h0, 0, 0, 32'h0, 6'h00);
            tick();
        end
        no_op();
        check_val("cnt_reg3", 64'(retired_count), CNT_ON ? 64'd3 : 64'd0);
        put_op(1, 0, 0, 0, 3'd0, 64'h1111_2222_3333_4444, 3'b111, 32'h0000_1000, 0, 0, 32'h0, 6'h00);
        tick();
        no_op();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("cnt_hi_pending", 64'(retired_count), CNT_ON ? 64'd3 : 64'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("cnt_store_done", 64'(retired_count), CNT_ON ? 64'd4 : 64'd0);

        // Reset asserted mid-store (in MEM_HI) takes effect without a clock edge
        put_op(1, 0, 0, 0, 3'd0, 64'hAAAA_AAAA_BBBB_BBBB, 3'b111, 32'h0000_2000, 0, 0, 32'h0, 6'h00);
        tick();
        no_op();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("rst_mid_hi_addr", 64'(mem_addr), 64'h2004);
        #2;
        reset = 1'b0;
        #1;
        check_val("rst_mid_req",   64'(mem_req), 64'd0);
        check_val("rst_mid_count", 64'(retired_count), 64'd0);
        check_val("rst_mid_ready", 64'(wb_bus.wb_ready), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check_val("rst_mid_after", 64'(mem_req), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
